// File: rtl/obstacle_scroller_if.sv
// Gap-position handshake between the random source (master) and the obstacle scroller (slave).
interface obstacle_scroller_if #(
  parameter int ROWS = 16
);
  logic [$clog2(ROWS)-1:0] gap_pos;
  logic                    gap_valid;
  logic                    gap_ready;

  modport master (output gap_pos, output gap_valid, input  gap_ready);
  modport slave  (input  gap_pos, input  gap_valid, output gap_ready);
endinterface

// File: rtl/obstacle_scroller.sv
// Scrolling pipe-obstacle grid for the LED-matrix game: shifts toward column 0 on each speed tick,
// injecting pipe columns from a one-entry gap buffer at the right edge.
module obstacle_scroller #(
  parameter int ROWS     = 16,
  parameter int COLS     = 16,
  parameter int GAP_W    = 4,
  parameter int SPACING  = 4,
  parameter int BIRD_COL = 3,
  parameter int DIV_W    = 24
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       pause,
  input  logic                       halt,
  input  logic [DIV_W-1:0]           speed_div,
  obstacle_scroller_if.slave         gap,
  output logic [ROWS-1:0][COLS-1:0]  grid,
  output logic                       step,
  output logic                       pipe_passed,
  output logic                       running
);
  localparam int RW  = $clog2(ROWS);
  localparam int SPW = (SPACING < 1) ? 1 : $clog2(SPACING + 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED} state_t;

  state_t           state;
  logic [COLS-1:0]  marker;
  logic [DIV_W-1:0] tick_cnt;
  logic [SPW-1:0]   spc_cnt;
  logic             buf_valid;
  logic [RW-1:0]    buf_pos;

  logic [DIV_W-1:0] eff_m1;
  logic             scroll;
  logic             inject_pipe;
  logic [RW-1:0]    gap_top;
  logic [ROWS-1:0]  inject_col;

  assign gap.gap_ready = ~buf_valid;
  assign running       = (state == RUN);

  always_comb begin
    eff_m1      = (speed_div == '0) ? '0 : speed_div - DIV_W'(1);
    // start/halt/pause all win over a pending tick
    scroll      = (state == RUN) && !start && !halt && !pause && (tick_cnt >= eff_m1);
    inject_pipe = (spc_cnt == '0) && buf_valid;
    gap_top     = (buf_pos > RW'(ROWS - GAP_W)) ? RW'(ROWS - GAP_W) : buf_pos;
    inject_col  = '0;
    for (int r = 0; r < ROWS; r++)
      inject_col[r] = inject_pipe && !((r >= int'(gap_top)) && (r < int'(gap_top) + GAP_W));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      grid        <= '0;
      marker      <= '0;
      tick_cnt    <= '0;
      spc_cnt     <= '0;
      buf_valid   <= 1'b0;
      buf_pos     <= '0;
      step        <= 1'b0;
      pipe_passed <= 1'b0;
    end else begin
      step        <= scroll;
      pipe_passed <= scroll && marker[BIRD_COL];

      // Accept needs an empty buffer and consume needs a full one, so they never collide.
      if (!buf_valid && gap.gap_valid) begin
        buf_valid <= 1'b1;
        buf_pos   <= gap.gap_pos;
      end

      if (start) begin
        grid     <= '0;
        marker   <= '0;
        tick_cnt <= '0;
        spc_cnt  <= '0;
        state    <= pause ? PAUSED : RUN;
      end else if (halt && state != IDLE) begin
        state <= IDLE;
      end else begin
        case (state)
          RUN: begin
            if (pause) begin
              state <= PAUSED;
            end else if (scroll) begin
              tick_cnt <= '0;
              for (int r = 0; r < ROWS; r++)
                grid[r] <= {inject_col[r], grid[r][COLS-1:1]};
              marker <= {inject_pipe, marker[COLS-1:1]};
              if (inject_pipe) begin
                spc_cnt   <= SPW'(SPACING);
                buf_valid <= 1'b0;
              end else if (spc_cnt != '0) begin
                spc_cnt <= spc_cnt - SPW'(1);
              end
            end else begin
              tick_cnt <= tick_cnt + DIV_W'(1);
            end
          end
          PAUSED: if (!pause) state <= RUN;
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_obstacle_scroller.sv
// Directed bench: the driver queues the expected grid/pass/cycle for each step, a monitor checks each step pulse.
module tb_obstacle_scroller;
  localparam int ROWS = 16;
  localparam int COLS = 16;

  typedef logic [ROWS-1:0][COLS-1:0] grid_t;
  typedef struct {
    int    cyc;
    grid_t grid;
    logic  passed;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        pause = 1'b0;
  logic        halt = 1'b0;
  logic [23:0] speed_div = '0;
  grid_t       grid;
  logic        step, pipe_passed, running;

  obstacle_scroller_if #(.ROWS(ROWS)) gif ();

  obstacle_scroller #(
    .ROWS(ROWS), .COLS(COLS), .GAP_W(4), .SPACING(4), .BIRD_COL(3), .DIV_W(24)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .pause(pause), .halt(halt),
    .speed_div(speed_div), .gap(gif), .grid(grid), .step(step),
    .pipe_passed(pipe_passed), .running(running)
  );

  always #5 clk = ~clk;

  int    cyc = 0;
  int    t0 = 0;
  int    tests = 0;
  int    fails = 0;
  string phase = "init";
  exp_t  q[$];
  exp_t  e_mon;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string nm, longint act, longint expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s/%s: got %0d expected %0d (cyc %0d)", phase, nm, act, expv, cyc);
    end
  endtask

  task automatic check_grid(string nm, grid_t act, grid_t expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s/%s: got %h expected %h (cyc %0d)", phase, nm, act, expv, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (step) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL %s/unexpected_step: got step=1 expected none (cyc %0d)", phase, cyc);
      end else begin
        e_mon = q.pop_front();
        check("step_cyc", cyc, e_mon.cyc);
        check_grid("step_grid", grid, e_mon.grid);
        check("pipe_passed", pipe_passed, e_mon.passed);
      end
    end else if (pipe_passed) begin
      tests++;
      fails++;
      $display("FAIL %s/stray_pass: got pipe_passed=1 expected 0 (cyc %0d)", phase, cyc);
    end
  end

  function automatic grid_t add_pipe(grid_t g, int col, int top);
    for (int r = 0; r < ROWS; r++) g[r][col] = !((r >= top) && (r < top + 4));
    return g;
  endfunction

  task automatic push(int c, grid_t g, logic p);
    exp_t e;
    e.cyc = c; e.grid = g; e.passed = p;
    q.push_back(e);
  endtask

  task automatic goto(int c);
    while (cyc < c) begin @(posedge clk); #1; end
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    t0 = cyc;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic drain(int budget);
    for (int i = 0; i < budget && q.size() != 0; i++) begin @(posedge clk); #1; end
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL %s/drain: got %0d steps outstanding expected 0", phase, q.size());
      q.delete();
    end
  endtask

  initial begin
    grid_t g, g1, g2, g3;
    int ks[4];
    gif.gap_pos = '0;
    gif.gap_valid = 1'b0;

    phase = "reset";
    do_reset();
    check("running", running, 0);
    check("step", step, 0);
    check("pipe_passed", pipe_passed, 0);
    check("gap_ready", gif.gap_ready, 1);
    check_grid("grid", grid, '0);

    // gap 5 held valid, step every 3 cycles, pipes every 5 steps
    phase = "t1";
    gif.gap_pos = 4'd5;
    gif.gap_valid = 1'b1;
    @(posedge clk); #1;
    check("accept_in_idle", gif.gap_ready, 0);
    speed_div = 24'd3;
    do_start();
    check("running", running, 1);
    ks = '{1, 6, 11, 16};
    for (int n = 1; n <= 20; n++) begin
      g = '0;
      foreach (ks[i]) if (n >= ks[i] && n - ks[i] <= 15) g = add_pipe(g, 15 - (n - ks[i]), 5);
      push(t0 + 3 * n, g, (n == 14 || n == 19));
    end
    drain(80);
    gif.gap_valid = 1'b0;
    do_reset();
    check("midrun_reset_grid_zero", (grid == '0), 1);
    check("midrun_reset_running", running, 0);
    check("midrun_reset_ready", gif.gap_ready, 1);

    // 10 empty steps, then gap 14 clamped to 12; pipe tracked until gone
    phase = "t2";
    speed_div = 24'd2;
    do_start();
    for (int n = 1; n <= 27; n++) begin
      g = '0;
      if (n >= 11 && n - 11 <= 15) g = add_pipe(g, 15 - (n - 11), 12);
      push(t0 + 2 * n, g, (n == 24));
    end
    goto(t0 + 20);
    check("ready_before", gif.gap_ready, 1);
    gif.gap_pos = 4'd14;
    gif.gap_valid = 1'b1;
    goto(t0 + 21);
    gif.gap_valid = 1'b0;
    check("ready_low_after_accept", gif.gap_ready, 0);
    goto(t0 + 22);
    check("ready_after_consume", gif.gap_ready, 1);
    drain(80);
    check_grid("grid_empty_after_pipe", grid, '0);

    // pause mid-count keeps phase, halt on a step edge suppresses it
    do_reset();
    phase = "t5";
    speed_div = 24'd4;
    gif.gap_pos = 4'd0;
    gif.gap_valid = 1'b1;
    @(posedge clk); #1;
    gif.gap_valid = 1'b0;
    do_start();
    g1 = add_pipe('0, 15, 0);
    g2 = add_pipe('0, 14, 0);
    g3 = add_pipe('0, 13, 0);
    push(t0 + 4, g1, 1'b0);
    push(t0 + 8, g2, 1'b0);
    push(t0 + 20, g3, 1'b0);
    goto(t0 + 9);
    pause = 1'b1;
    goto(t0 + 13);
    check("paused_running", running, 0);
    check_grid("paused_grid", grid, g2);
    goto(t0 + 16);
    pause = 1'b0;
    goto(t0 + 23);
    halt = 1'b1;
    goto(t0 + 24);
    halt = 1'b0;
    check("halt_running", running, 0);
    check("halt_step", step, 0);
    check_grid("halt_grid", grid, g3);
    goto(t0 + 30);
    check_grid("idle_grid_frozen", grid, g3);
    drain(5);
    do_start();
    check_grid("restart_grid", grid, '0);
    check("restart_running", running, 1);
    do_reset();

    // speed 0 -> every cycle; 10 -> 2 with tick at 6 steps next cycle
    phase = "t6";
    speed_div = 24'd0;
    do_start();
    push(t0 + 1, '0, 1'b0);
    push(t0 + 2, '0, 1'b0);
    push(t0 + 3, '0, 1'b0);
    push(t0 + 10, '0, 1'b0);
    push(t0 + 12, '0, 1'b0);
    goto(t0 + 3);
    speed_div = 24'd10;
    goto(t0 + 9);
    speed_div = 24'd2;
    drain(30);
    halt = 1'b1;
    @(posedge clk); #1;
    halt = 1'b0;
    check("halt_suppress_step", step, 0);
    check("halt_idle", running, 0);
    repeat (3) @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
